// File: rtl/ddr_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rx_deser
//  Purpose  : DDR serial receiver. Samples din on both clock edges, hunts for
//             a sync word at either bit phase, then assembles aligned
//             WIDTH-bit words and presents them on a valid/ready interface
//             with a one-word holding register and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rx_deser #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
  parameter int               MAX_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             overflow,
  input  logic             ovf_clr
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int C_HALF   = WIDTH / 2;            // bit pairs per word
  localparam int C_FILL_W = $clog2(C_HALF + 2);   // valid-pair counter width
  localparam int C_BCNT_W = $clog2(C_HALF);       // pair-in-word counter width
  localparam int C_GAP_W  = $clog2(MAX_GAP + 1);  // gap counter width

  // An even-phase word needs C_HALF valid pairs; an odd-phase word reaches one
  // bit further back, into the pair before that.
  localparam logic [C_FILL_W-1:0] c_fill_even = C_FILL_W'(C_HALF);
  localparam logic [C_FILL_W-1:0] c_fill_odd  = C_FILL_W'(C_HALF + 1);
  localparam logic [C_FILL_W-1:0] c_fill_one  = C_FILL_W'(1);
  localparam logic [C_BCNT_W-1:0] c_bcnt_last = C_BCNT_W'(C_HALF - 1);
  localparam logic [C_BCNT_W-1:0] c_bcnt_one  = C_BCNT_W'(1);
  localparam logic [C_GAP_W-1:0]  c_gap_max   = C_GAP_W'(MAX_GAP);
  localparam logic [C_GAP_W-1:0]  c_gap_one   = C_GAP_W'(1);

  // Receiver state encoding
  localparam logic [0:0] c_st_hunt   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and next-state signals
  // --------------------------------------------------------------------------
  logic                rise_q;       // bit sampled at the last posedge
  logic                fall_q;       // bit sampled at the last negedge
  logic                pair_vld_q;   // pair now being captured is enabled data

  logic [WIDTH:0]      win_q,   win_d;    // shift window, newest pair in [1:0]
  logic [C_FILL_W-1:0] fill_q,  fill_d;   // valid pairs in window (saturating)
  logic                new_q,   new_d;    // a pair entered at the last posedge

  logic [0:0]          state_q, state_d;
  logic                phase_q, phase_d;  // 1: words end on a rise bit
  logic [C_BCNT_W-1:0] bcnt_q,  bcnt_d;   // pairs of the current word so far
  logic [C_GAP_W-1:0]  gap_q,   gap_d;    // consecutive non-sync words

  logic [WIDTH-1:0]    data_q,  data_d;
  logic                valid_q, valid_d;
  logic                ovf_q,   ovf_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_even_word;   // word ending at the newest fall bit
  logic [WIDTH-1:0] w_odd_word;    // word ending at the newest rise bit
  logic [WIDTH-1:0] w_word;        // word at the recorded phase
  logic             w_even_hit;
  logic             w_odd_hit;
  logic             w_deliver;     // a non-sync word completed and is offered
  logic             w_load;
  logic             w_drop;
  logic             w_take;

  assign w_even_word = win_q[WIDTH-1:0];
  assign w_odd_word  = win_q[WIDTH:1];
  assign w_word      = phase_q ? w_odd_word : w_even_word;

  // Sync matches are only trusted on a freshly shifted window whose bits all
  // arrived since the last flush, so stale or reset-filled bits never alias.
  assign w_even_hit = new_q && (fill_q >= c_fill_even) && (w_even_word == SYNC_WORD);
  assign w_odd_hit  = new_q && (fill_q >= c_fill_odd)  && (w_odd_word  == SYNC_WORD);

  // --------------------------------------------------------------------------
  // Pin capture
  // --------------------------------------------------------------------------

  // Rise-edge sample, tagged with whether the receiver is enabled right now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q     <= 1'b0;
      pair_vld_q <= 1'b0;
    end else begin
      rise_q     <= din;
      pair_vld_q <= en;
    end
  end

  // Fall-edge sample completing the pair started at the preceding posedge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= din;
    end
  end

  // --------------------------------------------------------------------------
  // Shift window
  // --------------------------------------------------------------------------

  // Shift in one (rise, fall) pair per cycle; disabling flushes everything.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    new_d  = 1'b0;
    if (!en) begin
      win_d  = '0;
      fill_d = '0;
    end else if (pair_vld_q) begin
      win_d = {win_q[WIDTH-2:0], rise_q, fall_q};
      new_d = 1'b1;
      if (fill_q != c_fill_odd) begin
        fill_d = fill_q + c_fill_one;
      end
    end
  end

  // Window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
      new_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      new_q  <= new_d;
    end
  end

  // --------------------------------------------------------------------------
  // Alignment state machine
  // --------------------------------------------------------------------------

  // Hunt for sync at both phases, then count pairs into aligned words.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    gap_d     = gap_q;
    w_deliver = 1'b0;
    if (!en) begin
      state_d = c_st_hunt;
      bcnt_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        c_st_hunt: begin
          bcnt_d = '0;
          gap_d  = '0;
          if (w_even_hit) begin
            state_d = c_st_locked;
            phase_d = 1'b0;
          end else if (w_odd_hit) begin
            state_d = c_st_locked;
            phase_d = 1'b1;
          end
        end
        c_st_locked: begin
          if (new_q) begin
            if (bcnt_q == c_bcnt_last) begin
              bcnt_d = '0;
              if (w_word == SYNC_WORD) begin
                // Periodic resync marker: consumed, refreshes the gap budget.
                gap_d = '0;
              end else if (gap_q == c_gap_max) begin
                // Too long without a marker: assume alignment is lost.
                state_d = c_st_hunt;
                gap_d   = '0;
              end else begin
                gap_d     = gap_q + c_gap_one;
                w_deliver = 1'b1;
              end
            end else begin
              bcnt_d = bcnt_q + c_bcnt_one;
            end
          end
        end
        default: begin
          state_d = c_st_hunt;
        end
      endcase
    end
  end

  // State machine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_hunt;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register
  // --------------------------------------------------------------------------
  assign w_take = valid_q && out_ready;
  assign w_load = w_deliver && (!valid_q || out_ready);
  assign w_drop = w_deliver && valid_q && !out_ready;

  // Load on empty or pass-through handshake; otherwise keep the held word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (w_load) begin
      data_d  = w_word;
      valid_d = 1'b1;
    end else if (w_take) begin
      valid_d = 1'b0;
    end
    // Clear wins over a simultaneous drop; that drop event is not recorded.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (w_drop) begin
      ovf_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign locked    = (state_q == c_st_locked);
  assign overflow  = ovf_q;

endmodule
`default_nettype wire
